line_fill_unit: RTL and testbench

//  Miss handler between the cache ways and the next memory level.
//  - On a miss it writes back the dirty victim line, if any, one word at a time.
//  - It then reads the missing line one word per memory transfer.
//  - It drives one victim way with a one-cycle allocate pulse, line_address and fetched_line.
//  - Upstream stage of each way's allocate/line_address/fetched_line inputs.

---
 rtl/line_fill_unit_if.sv | 23 ++
 rtl/line_fill_unit.sv | 193 +++++++++++++++++++
 tb/tb_line_fill_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_unit_if.sv
// Memory-side bus of the line fill unit: one word transfer per mem_req & mem_ready.
// The fill unit is the master; the next memory level is the slave.
interface line_fill_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/line_fill_unit.sv
// Line fill unit: services a cache miss by writing back a dirty victim line word
// by word, reading the missing line word by word, then pulsing allocate to the
// victim way together with the assembled line and its base address.
// All outputs are registered; they are computed from the next-state values.
module line_fill_unit #(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32,
  localparam int W         = BLOCK_SIZE / (DATA_WIDTH / 8),
  localparam int OFF       = $clog2(W),
  localparam int TAG_WIDTH = ADDRESS_WIDTH - OFF,
  localparam int WAY_W     = $clog2(NUM_WAYS),
  localparam int LINE_W    = W * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     miss_req,
  input  logic [ADDRESS_WIDTH-1:0] miss_addr,
  input  logic [WAY_W-1:0]         victim_way,
  input  logic                     victim_dirty,
  input  logic [TAG_WIDTH-1:0]     victim_tag,
  input  logic [LINE_W-1:0]        victim_line,
  output logic                     miss_ack,
  output logic                     busy,
  line_fill_unit_if.master         mem,
  output logic [NUM_WAYS-1:0]      allocate,
  output logic [ADDRESS_WIDTH-1:0] line_address,
  output logic [LINE_W-1:0]        fetched_line
);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, ALLOC = 2'd3} state_t;

  localparam logic [OFF-1:0]      CNT_LAST = OFF'(W - 1);
  localparam logic [OFF-1:0]      CNT_ONE  = OFF'(1'b1);
  localparam logic [NUM_WAYS-1:0] WAY_ONE  = NUM_WAYS'(1'b1);

  state_t                   state_r, state_s;
  logic [OFF-1:0]           cnt_r, cnt_s;
  logic [ADDRESS_WIDTH-1:0] base_r, base_s;
  logic [TAG_WIDTH-1:0]     tag_r, tag_s;
  logic [WAY_W-1:0]         way_r, way_s;
  logic [LINE_W-1:0]        victim_r, victim_s;
  logic                     accept_s, xfer_s, fill_xfer_s;

  logic                     mem_req_r, mem_req_s;
  logic                     mem_we_r, mem_we_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_WIDTH-1:0]    mem_wdata_r, mem_wdata_s;
  logic [NUM_WAYS-1:0]      allocate_r, allocate_s;
  logic                     miss_ack_r, busy_r;
  logic [ADDRESS_WIDTH-1:0] line_address_r;
  logic [LINE_W-1:0]        fetched_line_r;

  // Word-offset bits of the miss address never matter: the line base is aligned.
  logic unused_offset_s;
  assign unused_offset_s = ^miss_addr[OFF-1:0];

  assign miss_ack      = miss_ack_r;
  assign busy          = busy_r;
  assign allocate      = allocate_r;
  assign line_address  = line_address_r;
  assign fetched_line  = fetched_line_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;

  // Next state, word counter and captured miss context.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    xfer_s      = mem_req_r & mem.mem_ready;
    fill_xfer_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (miss_req) begin
          accept_s = 1'b1;
          cnt_s    = {OFF{1'b0}};
          state_s  = victim_dirty ? WB : FILL;
        end else begin
          state_s = IDLE;
        end
      end
      WB: begin
        if (xfer_s) begin
          cnt_s   = cnt_r + CNT_ONE;
          state_s = (cnt_r == CNT_LAST) ? FILL : WB;
        end else begin
          state_s = WB;
        end
      end
      FILL: begin
        if (xfer_s) begin
          fill_xfer_s = 1'b1;
          cnt_s       = cnt_r + CNT_ONE;
          state_s     = (cnt_r == CNT_LAST) ? ALLOC : FILL;
        end else begin
          state_s = FILL;
        end
      end
      ALLOC: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {OFF{1'b0}};
      end
    endcase

    if (accept_s) begin
      base_s   = {miss_addr[ADDRESS_WIDTH-1:OFF], {OFF{1'b0}}};
      tag_s    = victim_tag;
      way_s    = victim_way;
      victim_s = victim_line;
    end else begin
      base_s   = base_r;
      tag_s    = tag_r;
      way_s    = way_r;
      victim_s = victim_r;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDRESS_WIDTH{1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    allocate_s  = {NUM_WAYS{1'b0}};
    case (state_s)
      WB: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {tag_s, cnt_s};
        mem_wdata_s = victim_s[cnt_s * DATA_WIDTH +: DATA_WIDTH];
      end
      FILL: begin
        mem_req_s  = 1'b1;
        mem_addr_s = {base_s[ADDRESS_WIDTH-1:OFF], cnt_s};
      end
      ALLOC: begin
        allocate_s = WAY_ONE << way_s;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, context and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      cnt_r          <= {OFF{1'b0}};
      base_r         <= {ADDRESS_WIDTH{1'b0}};
      tag_r          <= {TAG_WIDTH{1'b0}};
      way_r          <= {WAY_W{1'b0}};
      victim_r       <= {LINE_W{1'b0}};
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r    <= {DATA_WIDTH{1'b0}};
      allocate_r     <= {NUM_WAYS{1'b0}};
      miss_ack_r     <= 1'b0;
      busy_r         <= 1'b0;
      line_address_r <= {ADDRESS_WIDTH{1'b0}};
      fetched_line_r <= {LINE_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      base_r      <= base_s;
      tag_r       <= tag_s;
      way_r       <= way_s;
      victim_r    <= victim_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      allocate_r  <= allocate_s;
      miss_ack_r  <= (state_s == ALLOC);
      busy_r      <= (state_s != IDLE);
      if (accept_s) begin
        line_address_r <= base_s;
      end
      if (fill_xfer_s) begin
        fetched_line_r[cnt_r * DATA_WIDTH +: DATA_WIDTH] <= mem.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: a table of miss scenarios is driven,
// expected memory transfers are queued as each miss is issued and popped as the
// DUT performs them; allocate timing and contents are checked per miss.
module tb_line_fill_unit;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic [1:0]   victim_way;
  logic         victim_dirty;
  logic [28:0]  victim_tag;
  logic [255:0] victim_line;
  logic         miss_ack;
  logic         busy;
  logic [3:0]   allocate;
  logic [31:0]  line_address;
  logic [255:0] fetched_line;

  int n_pass  = 0;
  int n_total = 0;

  line_fill_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  line_fill_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .victim_way   (victim_way),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .miss_ack     (miss_ack),
    .busy         (busy),
    .mem          (bus),
    .allocate     (allocate),
    .line_address (line_address),
    .fetched_line (fetched_line)
  );

  always #5 clk = ~clk;

  // Memory model: read data is 0xA0 plus the word address.
  assign bus.mem_rdata = 32'hA0 + bus.mem_addr;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  way;
    logic        dirty;
    logic [28:0] tag;
    logic [31:0] line_base;
    logic [31:0] stalls;      // nibble k = stall cycles before FILL word k
    int          abort_word;  // assert reset before this FILL word, -1 = never
    logic        chg;         // scramble victim inputs during FILL
    logic        reassert;    // keep miss_req high after miss_ack
    int          exp_cyc;     // cycle of allocate counted from accept
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t exp_q[$];
  vec_t  vecs[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] first);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = first + 32'(i);
    return l;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                                  input logic [28:0] tag, input logic [31:0] line_base,
                                  input logic [31:0] stalls, input int abort_word,
                                  input logic chg, input logic reassert, input int exp_cyc);
    vec_t v;
    v.addr = addr; v.way = way; v.dirty = dirty; v.tag = tag; v.line_base = line_base;
    v.stalls = stalls; v.abort_word = abort_word; v.chg = chg; v.reassert = reassert;
    v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "_ack_busy"}, {miss_ack, busy}, 256'd0);
    check({name, "_mem"}, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 256'd0);
    check({name, "_alloc"}, allocate, 256'd0);
    check({name, "_line_addr"}, line_address, 256'd0);
    check({name, "_fetched"}, fetched_line, 256'd0);
  endtask

  task automatic run_miss(input vec_t v);
    logic [31:0] base;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  nib;
    xfer_t       x;
    int          cyc, k, sc;
    bit          done, stalled;
    base = {v.addr[31:3], 3'b000};
    if (v.dirty) begin
      for (int i = 0; i < 8; i++) begin
        x.we = 1'b1; x.addr = {v.tag, 3'(i)}; x.data = v.line_base + 32'(i);
        exp_q.push_back(x);
      end
    end
    for (int i = 0; i < 8; i++) begin
      x.we = 1'b0; x.addr = base + 32'(i); x.data = 32'd0;
      exp_q.push_back(x);
    end

    @(negedge clk);
    check("idle_busy", busy, 256'd0);
    check("idle_mem_req", bus.mem_req, 256'd0);
    miss_req     = 1'b1;
    miss_addr    = v.addr;
    victim_way   = v.way;
    victim_dirty = v.dirty;
    victim_tag   = v.tag;
    victim_line  = mk_line(v.line_base);
    cyc = 0; k = 0; sc = 0; done = 1'b0; stalled = 1'b0;
    prev_addr = 32'd0; prev_data = 32'd0;

    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (v.chg && cyc == 3) begin
        miss_addr    = 32'hDEAD_BEE0;
        victim_way   = ~v.way;
        victim_dirty = 1'b1;
        victim_tag   = 29'h0BAD_0000;
        victim_line  = mk_line(32'h7777_0000);
      end
      if (miss_ack) begin
        check("alloc_cycle", 256'(cyc), 256'(v.exp_cyc));
        check("alloc_onehot", allocate, 256'(4'b0001 << v.way));
        check("line_address", line_address, 256'(base));
        check("fetched_line", fetched_line, mk_line(32'hA0 + base));
        check("alloc_mem_req", {bus.mem_req, bus.mem_addr, bus.mem_wdata}, 256'd0);
        check("alloc_busy", busy, 256'd1);
        if (!v.reassert) miss_req = 1'b0;
        done = 1'b1;
      end else begin
        check("no_early_alloc", allocate, 256'd0);
        if (stalled) begin
          check("stall_req_held", bus.mem_req, 256'd1);
          check("stall_addr_data", {bus.mem_addr, bus.mem_wdata}, {prev_addr, prev_data});
        end
        if (bus.mem_req && !bus.mem_we && v.abort_word == k) begin
          reset_n = 1'b0;
          #1;
          check_all_zero("reset_mid_fill");
          exp_q.delete();
          bus.mem_ready = 1'b1;
          return;
        end
        nib = v.stalls[k*4 +: 4];
        if (bus.mem_req && !bus.mem_we && sc < int'(nib)) begin
          bus.mem_ready = 1'b0;
          sc++;
        end else begin
          bus.mem_ready = 1'b1;
        end
        if (bus.mem_req && bus.mem_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_transfer", bus.mem_addr, 256'hFFFF_FFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            check("xfer_we", bus.mem_we, 256'(x.we));
            check("xfer_addr", bus.mem_addr, 256'(x.addr));
            if (x.we) check("xfer_wdata", bus.mem_wdata, 256'(x.data));
          end
          if (!bus.mem_we) begin
            k++;
            sc = 0;
          end
          stalled = 1'b0;
        end else if (bus.mem_req) begin
          stalled   = 1'b1;
          prev_addr = bus.mem_addr;
          prev_data = bus.mem_wdata;
        end else begin
          stalled = 1'b0;
          check("idle_bus_zero", {bus.mem_addr, bus.mem_wdata}, 256'd0);
        end
      end
    end
    bus.mem_ready = 1'b1;
    if (!done) check("alloc_timeout", 256'd0, 256'd1);
    check("queue_drained", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic post_reset();
    miss_req = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {allocate, miss_ack, busy, bus.mem_req}, 256'd0);
    end
  endtask

  initial begin
    //               addr        way    dirty tag          line_base     stalls        abort chg   reas  cyc
    vecs[0] = mk_vec(32'h105,    2'd2,  1'b0, 29'h0,       32'h0,        32'h0,        3,    1'b0, 1'b0, 0);
    vecs[1] = mk_vec(32'h105,    2'd2,  1'b0, 29'h0,       32'h0,        32'h0,        -1,   1'b0, 1'b0, 9);
    vecs[2] = mk_vec(32'h2A0,    2'd1,  1'b1, 29'h3,       32'h50,       32'h0,        -1,   1'b0, 1'b0, 17);
    vecs[3] = mk_vec(32'h40,     2'd0,  1'b0, 29'h0,       32'h0,        32'h0020_0003, -1,  1'b0, 1'b0, 14);
    vecs[4] = mk_vec(32'h7F3,    2'd3,  1'b0, 29'h1234,    32'h11,       32'h0,        -1,   1'b1, 1'b1, 9);
    vecs[5] = mk_vec(32'h1238,   2'd1,  1'b1, 29'h1ABCDE,  32'h900,      32'h1000_0000, -1,  1'b0, 1'b0, 18);

    reset_n       = 1'b0;
    miss_req      = 1'b0;
    miss_addr     = 32'd0;
    victim_way    = 2'd0;
    victim_dirty  = 1'b0;
    victim_tag    = 29'd0;
    victim_line   = 256'd0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      run_miss(vecs[t]);
      if (vecs[t].abort_word >= 0) post_reset();
    end

    repeat (3) @(negedge clk);
    check("final_idle", {busy, allocate, bus.mem_req}, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
